// File: rtl/obuf_drain.sv
// obuf_drain: streams a contiguous OBUF region out to the DRAM write-back path.
//
// Reads go through the OBUF memory read port, which has a 1-cycle latency.
// Returned words land in a small skid FIFO, and the FIFO head drives the
// valid/ready output stream. A read is only requested when its data is
// guaranteed a FIFO slot, so the producer side never needs backpressure.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             1-cycle pulse, samples base_addr/num_words (ignored unless idle)
//   busy, done        transfer in progress / 1-cycle completion pulse
//   mem_read_*        OBUF read port (req, addr out; data in one cycle later)
//   out_valid/ready   output handshake; out_data is the FIFO head
//   out_last          marks the final word of the transfer
//   stall_cycles      only when OBUF_DRAIN_STALL_CNT_EN is defined: cycles with
//                     out_valid && !out_ready while busy (saturating)
//
// Build option: define OBUF_DRAIN_STALL_CNT_EN to add the stall counter port.
module obuf_drain #(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int COUNT_W        = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_W-1:0]        num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,
`ifdef OBUF_DRAIN_STALL_CNT_EN
  output logic [COUNT_W-1:0]        stall_cycles,
`endif
  output logic                      out_valid,
  output logic [MEM_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [COUNT_W-1:0]        num_q, issued_q, accepted_q, accepted_nxt;
  logic                      inflight;   // read issued last cycle, data arrives now

  logic [MEM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [FCW-1:0]            fifo_count;
  logic                      push, pop, credit_ok, accept_start;

  assign push      = inflight;
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (accepted_q == num_q - COUNT_W'(1));

  // Words already buffered plus the one still in the read pipe must leave a slot.
  assign credit_ok    = (fifo_count + FCW'(inflight)) < FCW'(FIFO_DEPTH);
  assign accepted_nxt = accepted_q + COUNT_W'(pop);
  assign accept_start = (state_q == S_IDLE) && start;

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    mem_read_req  = 1'b0;
    mem_read_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_words == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        busy          = 1'b1;
        mem_read_req  = (issued_q < num_q) && credit_ok;
        mem_read_addr = base_q + MEM_ADDR_WIDTH'(issued_q);
        if (mem_read_req && (issued_q == num_q - COUNT_W'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Look at this cycle's accept so done lands the cycle after the last word.
        if (!inflight && (accepted_nxt == num_q)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= mem_read_req;
      if (accept_start) begin
        base_q     <= base_addr;
        num_q      <= num_words;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (mem_read_req) issued_q <= issued_q + COUNT_W'(1);
        accepted_q <= accepted_nxt;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_read_data;
  end

  // The credit rule means a returning word always finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (fifo_count == FCW'(FIFO_DEPTH))));

`ifdef OBUF_DRAIN_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || accept_start)
      stall_cycles <= '0;
    else if (busy && out_valid && !out_ready && (stall_cycles != '1))
      stall_cycles <= stall_cycles + COUNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_obuf_drain.sv
module tb_obuf_drain;
  localparam int DW = 64;
  localparam int AW = 11;
  localparam int CW = 16;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic          busy, done, mem_read_req, out_valid, out_last;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data = '0, out_data;
  logic          out_ready = 1'b1;
`ifdef OBUF_DRAIN_STALL_CNT_EN
  logic [CW-1:0] stall_cycles;
`endif

  obuf_drain dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
`ifdef OBUF_DRAIN_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, tot_cnt = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {16'hCAFE, 26'd0, ~a, a};
  endfunction

  // OBUF memory model: 1-cycle read latency
  always @(posedge clk) if (mem_read_req) mem_read_data <= word_of(mem_read_addr);

  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_data_q[$];   // {last, data}

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int  req_total = 0, acc_total = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  int  first_req_cyc = -1, last_req_cyc = -1, first_vld_cyc = -1, start_cyc = 0;
  bit  gap_chk = 0;
  logic        stalled_prev = 1'b0;
  logic [DW:0] held = '0;

  always @(negedge clk) begin
    if (reset) stalled_prev = 1'b0;
    else begin
      if (mem_read_req) begin
        req_total++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        last_req_cyc = cyc;
        chk("credit", (req_total - acc_total) <= 4, 1);
        chk("req_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("rd_addr", mem_read_addr, exp_addr_q.pop_front());
      end
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (stalled_prev && out_valid) chk("stall_hold", {out_last, out_data}, held);
      if (out_valid && out_ready) begin
        acc_total++;
        last_acc_cyc = cyc;
        chk("out_expected", exp_data_q.size() != 0, 1);
        if (exp_data_q.size() != 0) chk("out_word", {out_last, out_data}, exp_data_q.pop_front());
      end
      stalled_prev = out_valid && !out_ready;
      held = {out_last, out_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (gap_chk) chk("done_gap", cyc - last_acc_cyc, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_rst();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_read_req, 0);
    chk("rst_addr", mem_read_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input int n, input bit gap);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back({(i == n - 1), word_of(a)});
    end
    first_req_cyc = -1; last_req_cyc = -1; first_vld_cyc = -1; gap_chk = gap;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = CW'(n); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin @(negedge clk); #1; k++; end
    chk("done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("data_drained", exp_data_q.size(), 0);
    chk("addr_drained", exp_addr_q.size(), 0);
  endtask

  initial begin
    int d0, k;
    repeat (3) @(posedge clk);
    #1;
    chk_rst();
    reset = 1'b0;

    // 1: base 0x010, n=8, full throughput
    start_xfer(11'h010, 8, 1);
    wait_done(100);
    chk("t1_req_lat", first_req_cyc - start_cyc, 1);
    chk("t1_vld_lat", first_vld_cyc - start_cyc, 3);
    chk("t1_req_span", last_req_cyc - first_req_cyc, 7);
    chk("t1_done_lat", done_cyc - start_cyc, 11);

    // 2: n=0 -> immediate done, no reads, no output
    start_xfer(11'h055, 0, 0);
    wait_done(20);
    chk("t2_done_lat", done_cyc - start_cyc, 1);
    chk("t2_no_req", first_req_cyc, -1);
    chk("t2_no_valid", first_vld_cyc, -1);

    // 3: address wrap 0x7FE, 0x7FF, 0x000, 0x001
    start_xfer(11'h7FE, 4, 1);
    wait_done(100);

    // 4: n=16 with random ready and a 10-cycle stall
    start_xfer(11'h200, 16, 1);
    fork
      begin
        repeat (6) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
        @(posedge clk); #1; out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        repeat (40) begin out_ready = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
        out_ready = 1'b1;
      end
      wait_done(300);
    join
    out_ready = 1'b1;

    // 5: reset mid-transfer, then a clean n=2 transfer
    start_xfer(11'h100, 16, 1);
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_rst();
    reset = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    req_total = 0; acc_total = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_discard", out_valid, 0);
    start_xfer(11'h020, 2, 1);
    wait_done(100);

`ifdef OBUF_DRAIN_STALL_CNT_EN
    // 6: three stalled valid cycles counted
    out_ready = 1'b0;
    start_xfer(11'h300, 4, 1);
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); #1; k++; end
    chk("t6_valid_seen", out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(100);
    chk("t6_stall_cycles", stall_cycles, 3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
